// File: rtl/inst_encoder.sv
// RV32I instruction encoder and sequential instruction-memory loader.
// Takes decoded instruction fields over valid/ready, range-checks the
// immediate, packs the 32-bit instruction word and writes it to the next
// sequential word address through an acknowledged write port.
//
// state | meaning
// IDLE  | waiting for a field bundle; ready_o = !full_o
// WRITE | imem_we_o held high with stable addr/wdata until imem_ack_i

module inst_encoder #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [6:0]                      opcode_i,
  input  logic [2:0]                      funct3_i,
  input  logic [6:0]                      funct7_i,
  input  logic [4:0]                      rd_i,
  input  logic [4:0]                      rs1_i,
  input  logic [4:0]                      rs2_i,
  input  logic [31:0]                     imm_i,
  input  logic                            start_i,
  output logic                            imem_we_o,
  output logic [31:0]                     imem_addr_o,
  output logic [31:0]                     imem_wdata_o,
  input  logic                            imem_ack_i,
  output logic [$clog2(IMEM_DEPTH+1)-1:0] count_o,
  output logic                            full_o,
  output logic                            err_o,
  output logic [1:0]                      err_code_o
);

  localparam int CW = $clog2(IMEM_DEPTH + 1);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OP    = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_BAD
  } fmt_t;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t        state;
  fmt_t          fmt;
  logic          is_shift;
  logic          fits_12;
  logic          fits_13;
  logic          fits_21;
  logic          shamt_ok;
  logic [1:0]    chk_code;
  logic [31:0]   enc_word;
  logic [CW-1:0] count_nxt;

  // Instruction format from the major opcode.
  always_comb begin
    fmt = FMT_BAD;
    case (opcode_i)
      OP_OP:                      fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   fmt = FMT_I;
      OP_STORE:                   fmt = FMT_S;
      OP_BRANCH:                  fmt = FMT_B;
      OP_JAL:                     fmt = FMT_J;
      OP_LUI, OP_AUIPC:           fmt = FMT_U;
      default:                    fmt = FMT_BAD;
    endcase
  end

  // Signed range predicates: a value fits in N bits when bits [31:N-1] agree.
  always_comb begin
    is_shift = (opcode_i == OP_IMM) && ((funct3_i == 3'b001) || (funct3_i == 3'b101));
    fits_12  = (&imm_i[31:11]) || (~|imm_i[31:11]);
    fits_13  = (&imm_i[31:12]) || (~|imm_i[31:12]);
    fits_21  = (&imm_i[31:20]) || (~|imm_i[31:20]);
    shamt_ok = ~|imm_i[31:5];
  end

  // Error classification; misalignment of B/J offsets is reported ahead of range.
  always_comb begin
    chk_code = ERR_NONE;
    case (fmt)
      FMT_R: chk_code = ERR_NONE;
      FMT_I: begin
        if (is_shift) begin
          if (!shamt_ok) chk_code = ERR_RANGE;
        end else if (!fits_12) begin
          chk_code = ERR_RANGE;
        end
      end
      FMT_S: begin
        if (!fits_12) chk_code = ERR_RANGE;
      end
      FMT_B: begin
        if (imm_i[0])      chk_code = ERR_ALIGN;
        else if (!fits_13) chk_code = ERR_RANGE;
      end
      FMT_J: begin
        if (imm_i[0])      chk_code = ERR_ALIGN;
        else if (!fits_21) chk_code = ERR_RANGE;
      end
      FMT_U: begin
        if (|imm_i[11:0]) chk_code = ERR_RANGE;
      end
      default: chk_code = ERR_OP;
    endcase
  end

  // Field packing for each format.
  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        if (is_shift) enc_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        else          enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_S: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
      FMT_J: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      FMT_U: enc_word = {imm_i[31:12], rd_i, opcode_i};
      default: enc_word = 32'h0;
    endcase
  end

  assign count_nxt = count_o + CW'(1);

  // Handshake / write sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ready_o      <= 1'b1;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= BASE_ADDR;
      imem_wdata_o <= 32'h0;
      count_o      <= '0;
      full_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= ERR_NONE;
    end else if (start_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      imem_we_o   <= 1'b0;
      imem_addr_o <= BASE_ADDR;
      count_o     <= '0;
      full_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            if (chk_code == ERR_NONE) begin
              imem_wdata_o <= enc_word;
              imem_we_o    <= 1'b1;
              ready_o      <= 1'b0;
              state        <= WRITE;
            end else if (!err_o) begin
              err_o      <= 1'b1;
              err_code_o <= chk_code;
            end
          end
        end
        WRITE: begin
          if (imem_ack_i) begin
            imem_we_o   <= 1'b0;
            count_o     <= count_nxt;
            imem_addr_o <= imem_addr_o + 32'd4;
            full_o      <= (count_nxt == CW'(IMEM_DEPTH));
            ready_o     <= (count_nxt != CW'(IMEM_DEPTH));
            state       <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          imem_we_o <= 1'b0;
          ready_o   <= !full_o;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder: accepts decoded instruction fields (opcode, funct3, funct7, rd, rs1, rs2, immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. It range-checks the immediate and writes accepted words sequentially into instruction memory over an acknowledged write port. It is the inverse of the pipeline's control/immediate decode path. It serves as the on-chip program loader and as a stimulus source for core-level tests.

## Interface
Parameters:
- IMEM_DEPTH, 256: capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.

Ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  field bundle valid.
- ready_o  out  1  encoder can accept a bundle.
- opcode_i  in  7  RV32I major opcode.
- funct3_i  in  3  funct3.
- funct7_i  in  7  funct7 (R-type and shift-immediates only).
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  immediate as a signed byte offset or value (U-type: full 32-bit value).
- start_i  in  1  synchronous restart: address/count to base, errors cleared.
- imem_we_o  out  1  write request.
- imem_addr_o  out  32  byte address = BASE_ADDR + 4*count_o.
- imem_wdata_o  out  32  encoded word.
- imem_ack_i  in  1  memory accepted the write (sampled while imem_we_o=1).
- count_o  out  $clog2(IMEM_DEPTH+1)  words written.
- full_o  out  1  count_o == IMEM_DEPTH.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  01 illegal opcode, 10 immediate out of range, 11 misaligned immediate; holds the first error.

## Operation
- Format by opcode:
  - 0110011 → R.
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - Anything else → illegal.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode. Exception: opcode 0010011 with funct3 001/101 packs funct7|imm[4:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - U: imm[31:12]|rd|opcode.
- Range checks (imm_i treated as signed):
  - I/S: -2048..2047.
  - Shift-immediate: 0..31.
  - B: -4096..4094.
  - J: -1048576..1048574.
  - U: imm[11:0] must be 0, else code 10.
  - B/J: imm[0]=1 gives code 11 (checked before range).
- FSM states:
  - IDLE: ready_o = !full_o.
    - valid_i & ready_o & no error: register the word, go to WRITE.
    - valid_i & ready_o & error: set err_o/err_code_o (if not already set), stay in IDLE, no write, count unchanged.
  - WRITE: imem_we_o=1 with addr/wdata held stable.
    - imem_ack_i: count_o += 1, go to IDLE.
    - No ack: stay in WRITE.
- start_i has priority in any state:
  - Aborts a pending write (imem_we_o low the next cycle).
  - count_o ← 0, err_o/err_code_o ← 0, state ← IDLE.
  - A valid_i in the same cycle is not accepted.
- Full: ready_o=0 and valid_i is ignored until start_i. count_o never exceeds IMEM_DEPTH, and the address never wraps.

## Timing
- Reset values:
  - state IDLE.
  - ready_o=1.
  - imem_we_o=0.
  - imem_addr_o=BASE_ADDR.
  - imem_wdata_o=0.
  - count_o=0.
  - full_o=0.
  - err_o=0.
  - err_code_o=00.
- Accept in cycle N (valid_i & ready_o at the edge):
  - imem_we_o=1 and wdata valid from N+1.
  - If ack is seen at N+1, count_o increments and ready_o=1 from N+2.
  - Peak throughput: 1 word per 2 cycles.
- Error accept at N: err_o=1 from N+1, ready_o stays 1.
- ready_o, imem_*_o, count_o, full_o and err_* are registered outputs; none depend combinationally on valid_i or imem_ack_i.
- Asynchronous reset mid-WRITE: imem_we_o drops immediately, with no count increment.

## Test plan
- addi: opcode 0010011, f3 000, rd 1, rs1 0, imm 5, ack at first WRITE cycle → imem_wdata_o=32'h0050_0093, addr=BASE_ADDR, count_o=1, ready_o back high 2 cycles after accept.
- add: opcode 0110011, f7 0, rd 3, rs1 1, rs2 2, with ack withheld 3 cycles → wdata=32'h0020_81B3 stable for 4 cycles of imem_we_o, addr=BASE_ADDR+4.
- beq: opcode 1100011, rs1 1, rs2 2, imm -8 → 32'hFE20_8CE3. jal: rd 1, imm 2048 → 32'h0010_00EF.
- Errors:
  - lui with imm 32'h1234_5001 → err_o=1, err_code_o=10, no imem_we_o, count unchanged.
  - A later opcode 7'h7F does not change err_code_o.
  - start_i clears both.
- Misaligned: B-type imm 3 → err_code_o=11, no write.
- IMEM_DEPTH=4: write 4 words → full_o=1, ready_o=0, a further valid_i is ignored. start_i during a stalled 5th cycle → count_o=0, addr=BASE_ADDR, ready_o=1.
